// File: rtl/iic_status_pio_in_pkg.sv
// Shared constants for the I2C status input PIO: register map and edge-select codes.
package iic_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

  // Per-bit edge selection on 32-bit vectors; callers zero-extend narrower ports.
  function automatic logic [31:0] edge_select(input int edge_type,
                                              input logic [31:0] rise,
                                              input logic [31:0] fall);
    logic [31:0] sel;
    case (edge_type)
      32'sd0:  sel = rise;
      32'sd1:  sel = fall;
      32'sd2:  sel = rise | fall;
      default: sel = rise;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/iic_status_pio_in_if.sv
// Avalon-MM slave bus plus interrupt line of the I2C status input PIO.
interface iic_status_pio_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (output address, chipselect, write_n, writedata,
                  input  readdata, irq);
  modport slave  (input  address, chipselect, write_n, writedata,
                  output readdata, irq);
endinterface

// File: rtl/iic_status_pio_in_sync_edge.sv
// Input synchroniser with a post-reset priming window and registered edge pulses.
module pio_sync_edge
  import iic_pio_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] edge_pulse
);

  localparam logic [2:0] PRIME_MAX = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
  logic [WIDTH-1:0]                  prev_r;
  logic [WIDTH-1:0]                  edge_pulse_r;
  logic [2:0]                        prime_cnt_r;
  logic                              primed_s;
  logic [31:0]                       sel_s;

  assign sync_in    = sync_r[SYNC_STAGES-1];
  assign edge_pulse = edge_pulse_r;
  // Edges are ignored until the chain has flushed its reset zeros.
  assign primed_s   = (prime_cnt_r == PRIME_MAX);

  // Edge selection on the synchronised sample versus the previous one
  always_comb begin
    sel_s = edge_select(EDGE_TYPE, 32'(sync_in & ~prev_r), 32'(~sync_in & prev_r));
  end

  // Synchroniser chain, previous sample, priming counter and edge pulse register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r       <= '0;
      prev_r       <= '0;
      prime_cnt_r  <= 3'd0;
      edge_pulse_r <= '0;
    end else begin
      sync_r       <= {sync_r[SYNC_STAGES-2:0], in_port};
      prev_r       <= sync_in;
      prime_cnt_r  <= primed_s ? prime_cnt_r : prime_cnt_r + 3'd1;
      edge_pulse_r <= primed_s ? sel_s[WIDTH-1:0] : '0;
    end
  end

endmodule

// File: rtl/iic_status_pio_in.sv
// Avalon-MM input PIO returning I2C engine status: data, irqmask and edgecapture
// registers with a level interrupt towards the CPU.
module iic_status_pio_in
  import iic_pio_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2,
  parameter int W1C         = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     in_port,
  iic_status_pio_in_if.slave   bus
);

  logic [WIDTH-1:0] sync_in_s;
  logic [WIDTH-1:0] edge_pulse_s;
  logic [WIDTH-1:0] irqmask_r;
  logic [WIDTH-1:0] edgecap_r;
  logic [WIDTH-1:0] edgecap_nxt_s;
  logic [31:0]      readdata_r;
  logic [31:0]      rd_mux_s;
  logic             wr_s;
  logic             unused_s;

  pio_sync_edge #(
    .WIDTH       (WIDTH),
    .EDGE_TYPE   (EDGE_TYPE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_port    (in_port),
    .sync_in    (sync_in_s),
    .edge_pulse (edge_pulse_s)
  );

  assign wr_s        = bus.chipselect & ~bus.write_n;
  assign unused_s    = ^bus.writedata;
  assign bus.readdata = readdata_r;
  assign bus.irq      = |(edgecap_r & irqmask_r);

  // Edgecapture next state; a fresh edge is OR-ed in after the clear so it wins
  always_comb begin
    edgecap_nxt_s = edgecap_r;
    if (wr_s && (bus.address == ADDR_EDGECAP)) begin
      if (W1C != 0) begin
        edgecap_nxt_s = edgecap_r & ~bus.writedata[WIDTH-1:0];
      end else begin
        edgecap_nxt_s = '0;
      end
    end else begin
      edgecap_nxt_s = edgecap_r;
    end
    edgecap_nxt_s = edgecap_nxt_s | edge_pulse_s;
  end

  // Read mux, zero-extended to the bus width
  always_comb begin
    rd_mux_s = 32'd0;
    case (bus.address)
      ADDR_DATA:    rd_mux_s = 32'(sync_in_s);
      ADDR_RSVD:    rd_mux_s = 32'd0;
      ADDR_IRQMASK: rd_mux_s = 32'(irqmask_r);
      ADDR_EDGECAP: rd_mux_s = 32'(edgecap_r);
      default:      rd_mux_s = 32'd0;
    endcase
  end

  // Register file and registered read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_r  <= '0;
      edgecap_r  <= '0;
      readdata_r <= 32'd0;
    end else begin
      if (wr_s && (bus.address == ADDR_IRQMASK)) begin
        irqmask_r <= bus.writedata[WIDTH-1:0];
      end else begin
        irqmask_r <= irqmask_r;
      end
      edgecap_r  <= edgecap_nxt_s;
      readdata_r <= rd_mux_s;
    end
  end

endmodule
